// File: rtl/apb_uart_fifo_if.sv
// APB slave bus bundle for the UART: zero-wait-state transfers with byte strobes
// and a slave error response.
interface apb_uart_fifo_if;
  logic [31:0] paddr;
  logic [31:0] pdata;
  logic [31:0] prdata;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [3:0]  pstb;
  logic        pready;
  logic        perr;

  modport master (
    output paddr, pdata, psel, penable, pwrite, pstb,
    input  prdata, pready, perr
  );

  modport slave (
    input  paddr, pdata, psel, penable, pwrite, pstb,
    output prdata, pready, perr
  );
endinterface

// File: rtl/apb_uart_fifo.sv
// APB UART: TX/RX circular FIFOs, runtime baud divisor with 16x oversampling,
// sticky overrun/framing flags and a registered level interrupt.
module apb_uart_fifo #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter logic [15:0] DIV_RESET  = 16'd53
) (
  input  logic           pclk,
  input  logic           preset,
  apb_uart_fifo_if.slave apb,
  input  logic           sRX,
  output logic           sTX,
  output logic           irq
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned BW = 3;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic [3:0] TC_LAST = 4'd15;
  localparam logic [3:0] TC_MID  = 4'd7;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // FIFO storage and pointers
  logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
  logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
  logic [PW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d, tx_cnt_c;
  logic [PW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d, rx_cnt_c;
  logic tx_empty_c, tx_full_c, tx_push_c, tx_pop_c;
  logic rx_empty_c, rx_full_c, rx_push_c, rx_pop_c;
  logic [DATA_BITS-1:0] tx_head_c, rx_head_c;

  // Control/status registers
  logic [15:0] div_q, div_d, baud_q, baud_d;
  logic        div_wr_c, tick_c;
  logic        rx_ie_q, rx_ie_d, txe_ie_q, txe_ie_d, err_ie_q, err_ie_d;
  logic        ovr_q, ovr_d, ferr_q, ferr_d, irq_q, irq_d;
  logic        ovr_set_c, ferr_set_c, clr_ovr_c, clr_ferr_c;
  logic        xfer_c, perr_c, tx_idle_c;
  logic [31:0] prdata_c, status_c, ctrl_c;

  // Serial engines
  logic [1:0]           tx_st_q, tx_st_d, rx_st_q, rx_st_d;
  logic [3:0]           tx_tc_q, tx_tc_d, rx_tc_q, rx_tc_d;
  logic [BW-1:0]        tx_bc_q, tx_bc_d, rx_bc_q, rx_bc_d;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  logic                 stx_q, stx_d, rx_s1_q, rx_s2_q;

  logic unused_ok;
  assign unused_ok = ^{apb.paddr[31:4], apb.paddr[1:0], apb.pdata[31:19], apb.pstb[3]};

  assign tx_cnt_c   = tx_wr_q - tx_rd_q;
  assign rx_cnt_c   = rx_wr_q - rx_rd_q;
  assign tx_empty_c = (tx_wr_q == tx_rd_q);
  assign rx_empty_c = (rx_wr_q == rx_rd_q);
  assign tx_full_c  = (tx_wr_q[AW] != tx_rd_q[AW]) && (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]);
  assign rx_full_c  = (rx_wr_q[AW] != rx_rd_q[AW]) && (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]);
  assign tx_head_c  = tx_mem[tx_rd_q[AW-1:0]];
  assign rx_head_c  = rx_mem[rx_rd_q[AW-1:0]];
  assign tx_wr_d    = tx_wr_q + PW'(tx_push_c);
  assign tx_rd_d    = tx_rd_q + PW'(tx_pop_c);
  assign rx_wr_d    = rx_wr_q + PW'(rx_push_c);
  assign rx_rd_d    = rx_rd_q + PW'(rx_pop_c);

  assign tx_idle_c = tx_empty_c && (tx_st_q == ST_IDLE);
  assign status_c  = {8'h00, 8'(tx_cnt_c), 8'(rx_cnt_c), 2'b00, ferr_q, ovr_q,
                      rx_full_c, tx_idle_c, tx_full_c, ~rx_empty_c};
  assign ctrl_c    = {13'd0, err_ie_q, txe_ie_q, rx_ie_q, div_q};

  assign xfer_c     = apb.psel & apb.penable;
  assign apb.pready = xfer_c;
  assign apb.perr   = perr_c;
  assign apb.prdata = prdata_c;
  assign sTX        = stx_q;
  assign irq        = irq_q;

  // Register decode; reads are combinational from registers and FIFO heads
  always_comb begin
    prdata_c   = '0;
    perr_c     = 1'b0;
    tx_push_c  = 1'b0;
    rx_pop_c   = 1'b0;
    div_d      = div_q;
    div_wr_c   = 1'b0;
    rx_ie_d    = rx_ie_q;
    txe_ie_d   = txe_ie_q;
    err_ie_d   = err_ie_q;
    clr_ovr_c  = 1'b0;
    clr_ferr_c = 1'b0;
    if (xfer_c) begin
      case (apb.paddr[3:2])
        2'd0: begin
          if (apb.pwrite) begin
            if (apb.pstb[0]) begin
              if (tx_full_c) perr_c = 1'b1;
              else           tx_push_c = 1'b1;
            end
          end else if (rx_empty_c) begin
            perr_c = 1'b1;
          end else begin
            rx_pop_c = 1'b1;
            prdata_c = 32'(rx_head_c);
          end
        end
        2'd1: begin
          if (apb.pwrite) begin
            if (apb.pstb[0]) begin
              clr_ovr_c  = apb.pdata[4];
              clr_ferr_c = apb.pdata[5];
            end
          end else begin
            prdata_c = status_c;
          end
        end
        2'd2: begin
          if (apb.pwrite) begin
            if (apb.pstb[0]) begin
              div_d[7:0] = apb.pdata[7:0];
              div_wr_c   = 1'b1;
            end
            if (apb.pstb[1]) begin
              div_d[15:8] = apb.pdata[15:8];
              div_wr_c    = 1'b1;
            end
            if (apb.pstb[2]) begin
              rx_ie_d  = apb.pdata[16];
              txe_ie_d = apb.pdata[17];
              err_ie_d = apb.pdata[18];
            end
          end else begin
            prdata_c = ctrl_c;
          end
        end
        default: perr_c = 1'b1;
      endcase
    end
  end

  // Baud tick every DIV+1 cycles; a divisor write restarts the period
  always_comb begin
    tick_c = (baud_q == 16'd0);
    if (div_wr_c)    baud_d = div_d;
    else if (tick_c) baud_d = div_q;
    else             baud_d = baud_q - 16'd1;
  end

  // TX frame sequencer: each state spans 16 ticks, stop chains straight into start
  always_comb begin
    tx_st_d  = tx_st_q;
    tx_tc_d  = tx_tc_q;
    tx_bc_d  = tx_bc_q;
    tx_sh_d  = tx_sh_q;
    stx_d    = stx_q;
    tx_pop_c = 1'b0;
    if (tick_c) begin
      case (tx_st_q)
        ST_IDLE: begin
          if (!tx_empty_c) begin
            tx_pop_c = 1'b1;
            tx_sh_d  = tx_head_c;
            tx_tc_d  = 4'd0;
            tx_st_d  = ST_START;
            stx_d    = 1'b0;
          end
        end
        ST_START: begin
          tx_tc_d = tx_tc_q + 4'd1;
          if (tx_tc_q == TC_LAST) begin
            tx_st_d = ST_DATA;
            tx_bc_d = '0;
            stx_d   = tx_sh_q[0];
          end
        end
        ST_DATA: begin
          tx_tc_d = tx_tc_q + 4'd1;
          if (tx_tc_q == TC_LAST) begin
            if (tx_bc_q == LAST_BIT) begin
              tx_st_d = ST_STOP;
              stx_d   = 1'b1;
            end else begin
              tx_bc_d = tx_bc_q + 3'd1;
              tx_sh_d = tx_sh_q >> 1;
              stx_d   = tx_sh_q[1];
            end
          end
        end
        default: begin
          tx_tc_d = tx_tc_q + 4'd1;
          if (tx_tc_q == TC_LAST) begin
            if (!tx_empty_c) begin
              tx_pop_c = 1'b1;
              tx_sh_d  = tx_head_c;
              tx_st_d  = ST_START;
              stx_d    = 1'b0;
            end else begin
              tx_st_d = ST_IDLE;
              stx_d   = 1'b1;
            end
          end
        end
      endcase
    end
  end

  // RX sampler: start validated mid-bit, then one sample per 16 ticks
  always_comb begin
    rx_st_d    = rx_st_q;
    rx_tc_d    = rx_tc_q;
    rx_bc_d    = rx_bc_q;
    rx_sh_d    = rx_sh_q;
    rx_push_c  = 1'b0;
    ovr_set_c  = 1'b0;
    ferr_set_c = 1'b0;
    if (tick_c) begin
      case (rx_st_q)
        ST_IDLE: begin
          if (!rx_s2_q) begin
            rx_st_d = ST_START;
            rx_tc_d = 4'd0;
          end
        end
        ST_START: begin
          if (rx_tc_q == TC_MID) begin
            if (rx_s2_q) begin
              rx_st_d = ST_IDLE;
            end else begin
              rx_st_d = ST_DATA;
              rx_tc_d = 4'd0;
              rx_bc_d = '0;
            end
          end else begin
            rx_tc_d = rx_tc_q + 4'd1;
          end
        end
        ST_DATA: begin
          if (rx_tc_q == TC_LAST) begin
            rx_sh_d = {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
            rx_tc_d = 4'd0;
            if (rx_bc_q == LAST_BIT) rx_st_d = ST_STOP;
            else                     rx_bc_d = rx_bc_q + 3'd1;
          end else begin
            rx_tc_d = rx_tc_q + 4'd1;
          end
        end
        default: begin
          if (rx_tc_q == TC_LAST) begin
            ferr_set_c = ~rx_s2_q;
            if (rx_full_c) ovr_set_c = 1'b1;
            else           rx_push_c = 1'b1;
            rx_st_d = ST_IDLE;
          end else begin
            rx_tc_d = rx_tc_q + 4'd1;
          end
        end
      endcase
    end
  end

  // New error events take priority over a same-cycle W1C
  always_comb begin
    ovr_d  = ovr_set_c | (ovr_q & ~clr_ovr_c);
    ferr_d = ferr_set_c | (ferr_q & ~clr_ferr_c);
    irq_d  = (rx_ie_q & ~rx_empty_c) | (txe_ie_q & tx_empty_c) | (err_ie_q & (ovr_q | ferr_q));
  end

  always_ff @(posedge pclk) begin
    if (tx_push_c) tx_mem[tx_wr_q[AW-1:0]] <= apb.pdata[DATA_BITS-1:0];
    if (rx_push_c) rx_mem[rx_wr_q[AW-1:0]] <= rx_sh_q;
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      div_q    <= DIV_RESET;
      baud_q   <= DIV_RESET;
      rx_ie_q  <= 1'b0;
      txe_ie_q <= 1'b0;
      err_ie_q <= 1'b0;
      ovr_q    <= 1'b0;
      ferr_q   <= 1'b0;
      irq_q    <= 1'b0;
      tx_st_q  <= ST_IDLE;
      tx_tc_q  <= '0;
      tx_bc_q  <= '0;
      tx_sh_q  <= '0;
      stx_q    <= 1'b1;
      rx_st_q  <= ST_IDLE;
      rx_tc_q  <= '0;
      rx_bc_q  <= '0;
      rx_sh_q  <= '0;
      rx_s1_q  <= 1'b1;
      rx_s2_q  <= 1'b1;
    end else begin
      tx_wr_q  <= tx_wr_d;
      tx_rd_q  <= tx_rd_d;
      rx_wr_q  <= rx_wr_d;
      rx_rd_q  <= rx_rd_d;
      div_q    <= div_d;
      baud_q   <= baud_d;
      rx_ie_q  <= rx_ie_d;
      txe_ie_q <= txe_ie_d;
      err_ie_q <= err_ie_d;
      ovr_q    <= ovr_d;
      ferr_q   <= ferr_d;
      irq_q    <= irq_d;
      tx_st_q  <= tx_st_d;
      tx_tc_q  <= tx_tc_d;
      tx_bc_q  <= tx_bc_d;
      tx_sh_q  <= tx_sh_d;
      stx_q    <= stx_d;
      rx_st_q  <= rx_st_d;
      rx_tc_q  <= rx_tc_d;
      rx_bc_q  <= rx_bc_d;
      rx_sh_q  <= rx_sh_d;
      rx_s1_q  <= sRX;
      rx_s2_q  <= rx_s1_q;
    end
  end

endmodule

// File: tb/tb_apb_uart_fifo.sv
// Directed + randomized bench for apb_uart_fifo: queue-based FIFO/flag model,
// serial frame decoder on sTX and a bit-level frame driver on sRX.
module tb_apb_uart_fifo;
  localparam int DEPTH = 16;
  localparam logic [31:0] A_DATA = 32'h0, A_STAT = 32'h4, A_CTRL = 32'h8, A_RSVD = 32'hC;

  logic pclk = 1'b0;
  logic preset;
  logic sTX, irq, rx_drv, loop_en;
  wire  sRX = loop_en ? sTX : rx_drv;

  apb_uart_fifo_if bus ();

  apb_uart_fifo dut (
    .pclk   (pclk),
    .preset (preset),
    .apb    (bus),
    .sRX    (sRX),
    .sTX    (sTX),
    .irq    (irq)
  );

  always #5 pclk = ~pclk;

  int unsigned cyc = 0;
  always @(posedge pclk) cyc++;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  m_rx[$];
  logic        m_ovr, m_ferr;
  logic [7:0]  tx_exp[$];
  logic [7:0]  tx_got[$];
  int unsigned tx_start_cyc[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status(input int rxn, input int txn, input bit idle);
    int s;
    s = (rxn != 0 ? 1 : 0) + (txn == DEPTH ? 2 : 0) + (idle ? 4 : 0) + (rxn == DEPTH ? 8 : 0)
      + (m_ovr ? 16 : 0) + (m_ferr ? 32 : 0) + rxn * 256 + txn * 65536;
    return 32'(s);
  endfunction

  task automatic apb(input bit wr, input logic [31:0] addr, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rd, output logic er);
    @(negedge pclk);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr;
    bus.paddr = addr; bus.pdata = d; bus.pstb = s;
    @(negedge pclk);
    bus.penable = 1'b1;
    #1;
    rd = bus.prdata;
    er = bus.perr;
    check("pready", 32'(bus.pready), 32'd1);
    @(posedge pclk); #1;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.pstb = 4'h0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp_d, input logic exp_e);
    logic [31:0] rd; logic er;
    apb(1'b0, addr, 32'h0, 4'h0, rd, er);
    check(tag, rd, exp_d);
    check({tag, "_perr"}, 32'(er), 32'(exp_e));
  endtask

  task automatic wr_chk(input string tag, input logic [31:0] addr, input logic [31:0] d,
                        input logic [3:0] s, input logic exp_e);
    logic [31:0] rd; logic er;
    apb(1'b1, addr, d, s, rd, er);
    check({tag, "_perr"}, 32'(er), 32'(exp_e));
  endtask

  // Model of one DATA read: pop the head, or expect the empty-FIFO error
  task automatic rd_data(input string tag);
    if (m_rx.size() == 0) rd_chk(tag, A_DATA, 32'h0, 1'b1);
    else                  rd_chk(tag, A_DATA, 32'(m_rx.pop_front()), 1'b0);
  endtask

  task automatic model_rx(input logic [7:0] ch, input logic stop);
    if (!stop) m_ferr = 1'b1;
    if (m_rx.size() == DEPTH) m_ovr = 1'b1;
    else                      m_rx.push_back(ch);
  endtask

  task automatic send_rx(input logic [7:0] ch, input logic stop);
    @(negedge pclk);
    for (int k = 0; k < 10; k++) begin
      rx_drv = (k == 0) ? 1'b0 : (k == 9) ? stop : ch[k-1];
      repeat (16) @(negedge pclk);
    end
    rx_drv = 1'b1;
  endtask

  task automatic tx_char(input string tag, input logic [7:0] ch);
    wr_chk(tag, A_DATA, 32'(ch), 4'h1, 1'b0);
    tx_exp.push_back(ch);
  endtask

  // Decodes frames on sTX at 16 cycles per bit, sampling at bit centres
  initial begin : tx_mon
    logic [7:0] ch;
    forever begin
      @(negedge pclk);
      if (sTX === 1'b0 && preset === 1'b0) begin
        tx_start_cyc.push_back(cyc);
        repeat (8) @(negedge pclk);
        for (int k = 0; k < 8; k++) begin
          repeat (16) @(negedge pclk);
          ch[k] = sTX;
        end
        repeat (16) @(negedge pclk);
        tx_got.push_back(ch);
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] rd;
    logic        er;
    logic [7:0]  ch;
    logic [9:0]  frame;
    int          lat;

    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = 32'h0; bus.pdata = 32'h0; bus.pstb = 4'h0;
    rx_drv = 1'b1; loop_en = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
    preset = 1'b1;
    repeat (3) @(negedge pclk);
    preset = 1'b0;

    // Reset state
    check("rst_stx", 32'(sTX), 32'd1);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_prdata", bus.prdata, 32'h0);
    rd_chk("rst_status", A_STAT, exp_status(0, 0, 1'b1), 1'b0);
    rd_chk("rst_ctrl", A_CTRL, 32'h0000_0035, 1'b0);
    rd_chk("rsvd_read", A_RSVD, 32'h0, 1'b1);
    wr_chk("rsvd_write", A_RSVD, 32'hFFFF_FFFF, 4'hF, 1'b1);
    rd_chk("ctrl_after_rsvd", A_CTRL, 32'h0000_0035, 1'b0);

    // Single character at DIV=0: start latency and bit-exact frame
    wr_chk("div0", A_CTRL, 32'h0, 4'h3, 1'b0);
    tx_char("tx55", 8'h55);
    lat = 0;
    while (sTX !== 1'b0 && lat < 4) begin
      @(negedge pclk);
      lat++;
    end
    check("tx_start_latency_ok", 32'(lat >= 1 && lat <= 2), 32'd1);
    frame = {1'b1, 8'h55, 1'b0};
    for (int k = 0; k < 10; k++) begin
      repeat (k == 0 ? 8 : 16) @(negedge pclk);
      check($sformatf("tx55_bit%0d", k), 32'(sTX), 32'(frame[k]));
    end
    apb(1'b0, A_STAT, 32'h0, 4'h0, rd, er);
    check("tx_busy_in_stop", 32'(rd[2]), 32'd0);
    repeat (8) @(negedge pclk);
    rd_chk("tx_idle_after", A_STAT, exp_status(0, 0, 1'b1), 1'b0);

    // Loopback: two back-to-back frames received in order
    loop_en = 1'b1;
    tx_char("txA5", 8'hA5); model_rx(8'hA5, 1'b1);
    tx_char("tx3C", 8'h3C); model_rx(8'h3C, 1'b1);
    repeat (360) @(negedge pclk);
    loop_en = 1'b0;
    check("tx_frames_seen", 32'(tx_start_cyc.size()), 32'd3);
    if (tx_start_cyc.size() >= 3)
      check("b2b_gap", tx_start_cyc[2] - tx_start_cyc[1], 32'd160);
    rd_chk("loop_status", A_STAT, exp_status(2, 0, 1'b1), 1'b0);
    rd_data("loop_rd0");
    rd_data("loop_rd1");
    rd_data("loop_rd_empty");

    // TX fill at a very slow baud, then RX overrun at DIV=0
    wr_chk("div_ffff", A_CTRL, 32'h0000_FFFF, 4'h3, 1'b0);
    for (int i = 0; i < DEPTH; i++) tx_char($sformatf("fill%0d", i), 8'($urandom));
    rd_chk("tx_full_status", A_STAT, exp_status(0, DEPTH, 1'b0), 1'b0);
    wr_chk("tx_overflow", A_DATA, 32'($urandom), 4'h1, 1'b1);
    rd_chk("tx_full_status2", A_STAT, exp_status(0, DEPTH, 1'b0), 1'b0);
    wr_chk("div0_again", A_CTRL, 32'h0, 4'h3, 1'b0);
    for (int i = 0; i <= DEPTH; i++) begin
      ch = 8'($urandom);
      send_rx(ch, 1'b1);
      model_rx(ch, 1'b1);
    end
    repeat (20) @(negedge pclk);
    rd_chk("ovr_status", A_STAT, exp_status(DEPTH, 0, 1'b1), 1'b0);
    check("irq_disabled", 32'(irq), 32'd0);
    wr_chk("w1c_ovr", A_STAT, 32'h10, 4'h1, 1'b0);
    m_ovr = 1'b0;
    rd_chk("ovr_cleared", A_STAT, exp_status(DEPTH, 0, 1'b1), 1'b0);
    for (int i = 0; i < DEPTH; i++) rd_data($sformatf("rx_drain%0d", i));
    check("tx_chars_count", 32'(tx_got.size()), 32'(tx_exp.size()));
    for (int i = 0; i < tx_exp.size() && i < tx_got.size(); i++)
      check($sformatf("tx_char%0d", i), 32'(tx_got[i]), 32'(tx_exp[i]));

    // Framing error, error interrupt latency, glitch rejection
    send_rx(8'h81, 1'b0);
    model_rx(8'h81, 1'b0);
    repeat (20) @(negedge pclk);
    rd_chk("ferr_status", A_STAT, exp_status(1, 0, 1'b1), 1'b0);
    wr_chk("set_err_ie", A_CTRL, 32'h0004_0000, 4'h4, 1'b0);
    check("irq_before", 32'(irq), 32'd0);
    @(posedge pclk); #1;
    check("irq_after", 32'(irq), 32'd1);
    @(negedge pclk);
    rx_drv = 1'b0;
    repeat (4) @(negedge pclk);
    rx_drv = 1'b1;
    repeat (40) @(negedge pclk);
    rd_chk("glitch_status", A_STAT, exp_status(1, 0, 1'b1), 1'b0);
    rd_data("ferr_char");

    // Asynchronous reset in the middle of a TX frame
    ch = 8'($urandom);
    send_rx(ch, 1'b1);
    wr_chk("tx00", A_DATA, 32'h0, 4'h1, 1'b0);
    repeat (40) @(negedge pclk);
    check("tx_mid_low", 32'(sTX), 32'd0);
    check("irq_pre_reset", 32'(irq), 32'd1);
    #2 preset = 1'b1;
    #1;
    check("rst_async_stx", 32'(sTX), 32'd1);
    check("rst_async_irq", 32'(irq), 32'd0);
    repeat (2) @(negedge pclk);
    preset = 1'b0;
    m_rx.delete();
    m_ovr = 1'b0;
    m_ferr = 1'b0;
    rd_chk("post_rst_status", A_STAT, exp_status(0, 0, 1'b1), 1'b0);
    rd_chk("post_rst_ctrl", A_CTRL, 32'h0000_0035, 1'b0);
    rd_data("post_rst_rx_empty");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
